// File: rtl/rr_mux_n_if.sv
// rr_mux_n_if: stream bundle between N producers, the round-robin mux and one consumer.
//   in_data   : CHANNELS*WIDTH flattened producer data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid from producers
//   in_ready  : per-channel ready back to producers (at most one bit high)
//   out_data  : registered data to the consumer
//   out_ch    : source channel of out_data
//   out_valid : output valid
//   out_ready : consumer ready
// slave  = the mux side, master = the producer/consumer environment.
interface rr_mux_n_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_ch;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel registered multiplexer with valid/ready on every input and
// on the output. Channel choice is either an external select (mode=0) or
// round-robin arbitration (mode=1). One output register stage.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   mode  : 0 = fixed select, 1 = round-robin
//   sel   : channel used in fixed mode (out-of-range never grants)
//   bus   : rr_mux_n_if slave modport carrying all stream signals
module rr_mux_n #(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  rr_mux_n_if.slave        bus
);

  localparam int unsigned SUM_W = SEL_W + 1;

  logic [WIDTH-1:0]      out_data_q;
  logic [SEL_W-1:0]      out_ch_q;
  logic                  out_valid_q;
  logic [SEL_W-1:0]      ptr_q;

  logic [2*CHANNELS-1:0] vld_dbl;
  logic [CHANNELS-1:0]   vld_rot;
  logic [SEL_W-1:0]      rr_off;
  logic [SUM_W-1:0]      rr_sum;
  logic                  grant_vld;
  logic [SEL_W-1:0]      grant_idx;
  logic [WIDTH-1:0]      grant_data;
  logic                  load;
  logic                  xfer;
  logic [CHANNELS-1:0]   in_ready_c;
  logic [SEL_W-1:0]      ptr_next;

  // Round-robin search: rotate valids so ptr sits at bit 0, take the lowest
  // set bit, then map the offset back to an absolute channel mod CHANNELS.
  always_comb begin
    vld_dbl = {bus.in_valid, bus.in_valid};
    vld_rot = CHANNELS'(vld_dbl >> ptr_q);
    rr_off  = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (vld_rot[i]) rr_off = SEL_W'(i);
    end
    rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
    if (rr_sum >= SUM_W'(CHANNELS)) rr_sum = rr_sum - SUM_W'(CHANNELS);
  end

  // Grant selection for both modes.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (mode) begin
      grant_vld = |bus.in_valid;
      grant_idx = rr_sum[SEL_W-1:0];
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (sel == SEL_W'(i) && bus.in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = sel;
        end
      end
    end
  end

  // Handshake: ready is gated by reset so a discarded cycle never looks accepted.
  always_comb begin
    load       = !out_valid_q || bus.out_ready;
    xfer       = rst_n && load && grant_vld;
    in_ready_c = '0;
    grant_data = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (grant_idx == SEL_W'(i)) begin
        in_ready_c[i] = xfer;
        grant_data    = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
    ptr_next = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else if (xfer) begin
      out_data_q  <= grant_data;
      out_ch_q    <= grant_idx;
      out_valid_q <= 1'b1;
      if (mode) ptr_q <= ptr_next;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed, table-driven bench for rr_mux_n (4-channel and 3-channel builds).
module tb_rr_mux_n;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] ch;
    logic [7:0] data;
  } vec_t;

  localparam int NV = 25;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic [1:0] sel;
  logic       mode3;
  logic [1:0] sel3;

  int n_total = 0;
  int n_pass  = 0;

  vec_t tbl [NV];

  rr_mux_n_if #(.WIDTH(8), .CHANNELS(4)) bus ();
  rr_mux_n_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

  rr_mux_n #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .bus(bus)
  );

  rr_mux_n #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One cycle on the 4-channel build: drive at negedge, check ready, check outputs after edge.
  task automatic step(input logic rst, input logic m, input logic [1:0] s,
                      input logic [3:0] v, input logic ordy, input logic [3:0] erdy,
                      input logic eov, input logic [1:0] ech, input logic [7:0] edata,
                      input string nm);
    @(negedge clk);
    rst_n         = rst;
    mode          = m;
    sel           = s;
    bus.in_valid  = v;
    bus.out_ready = ordy;
    #1;
    chk({nm, " in_ready"}, 64'(bus.in_ready), 64'(erdy));
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, 64'(bus.out_valid), 64'(eov));
    chk({nm, " out_ch"}, 64'(bus.out_ch), 64'(ech));
    chk({nm, " out_data"}, 64'(bus.out_data), 64'(edata));
  endtask

  // One cycle on the 3-channel build, fixed mode.
  task automatic step3(input logic [1:0] s, input logic [2:0] v, input logic [2:0] erdy,
                       input logic eov, input logic [1:0] ech, input string nm);
    @(negedge clk);
    mode3          = 1'b0;
    sel3           = s;
    bus3.in_valid  = v;
    bus3.out_ready = 1'b1;
    #1;
    chk({nm, " in_ready"}, 64'(bus3.in_ready), 64'(erdy));
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, 64'(bus3.out_valid), 64'(eov));
    chk({nm, " out_ch"}, 64'(bus3.out_ch), 64'(ech));
  endtask

  initial begin
    // mode sel vld ordy | rdy ov ch data  (ch0=11 ch1=3C ch2=A5 ch3=77)
    tbl[0]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
    tbl[1]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
    tbl[2]  = '{1'b0, 2'd2, 4'hB, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA5};
    tbl[3]  = '{1'b0, 2'd0, 4'h1, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h11};
    tbl[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    tbl[5]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h3C};
    tbl[6]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
    tbl[7]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h77};
    tbl[8]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    tbl[9]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h3C};
    tbl[10] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
    tbl[11] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h77};
    tbl[12] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h3C};
    tbl[13] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h77};
    tbl[14] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h3C};
    tbl[15] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h77};
    tbl[16] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h77};
    tbl[17] = '{1'b1, 2'd0, 4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h3C};
    for (int i = 18; i < 23; i++)
      tbl[i] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h3C};
    tbl[23] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
    tbl[24] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA5};

    rst_n          = 1'b0;
    mode           = 1'b1;
    sel            = 2'd0;
    bus.in_data    = {8'h77, 8'hA5, 8'h3C, 8'h11};
    bus.in_valid   = 4'h0;
    bus.out_ready  = 1'b1;
    mode3          = 1'b0;
    sel3           = 2'd0;
    bus3.in_data   = {8'hC3, 8'hB2, 8'h5A};
    bus3.in_valid  = 3'h0;
    bus3.out_ready = 1'b1;

    // Reset held two cycles with every input valid, then released idle.
    step(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, "rst0");
    step(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, "rst1");
    step(1'b1, 1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, "idle");

    for (int i = 0; i < NV; i++)
      step(1'b1, tbl[i].mode, tbl[i].sel, tbl[i].vld, tbl[i].ordy,
           tbl[i].rdy, tbl[i].ov, tbl[i].ch, tbl[i].data, $sformatf("vec%0d", i));

    // ptr is 3 here; load ch2 (scan 3,0,1,2) so out_valid=1 and ptr stays 3.
    step(1'b1, 1'b1, 2'd0, 4'h4, 1'b0, 4'b0100, 1'b1, 2'd2, 8'hA5, "pre_rst");
    // Mid-stream reset pulse: ready suppressed, word discarded.
    step(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, "mid_rst");
    step(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11, "post_rst");

    // Mode switch: rr granted 0 above, now 1 (ptr=2), fixed sel0 x3, then rr resumes at 2.
    step(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h3C, "rr1");
    step(1'b1, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11, "fix_a");
    step(1'b1, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11, "fix_b");
    step(1'b1, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11, "fix_c");
    step(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5, "rr_resume");

    // Three-channel build: out-of-range sel=3 never grants and the register drains.
    step3(2'd0, 3'b111, 3'b001, 1'b1, 2'd0, "c3_sel0");
    step3(2'd3, 3'b111, 3'b000, 1'b0, 2'd0, "c3_sel3a");
    step3(2'd3, 3'b111, 3'b000, 1'b0, 2'd0, "c3_sel3b");
    chk("c3 out_data", 64'(bus3.out_data), 64'(8'h5A));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rr_mux_n.md
# rr_mux_n

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. It is the successor to the combinational 2:1 mux: it serves CHANNELS producers onto one consumer, either by an externally driven select (fixed mode) or by round-robin arbitration. It has one output register stage. It sits between multiple streaming sources and a shared sink, for example a bus or UART transmit path.

## Interface
Parameters:
- WIDTH, 8, data width per channel (1..64)
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, derived as clog2(CHANNELS), width of select and channel-ID fields; not overridden

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SEL_W  channel used in fixed mode
- in_data  in  CHANNELS*WIDTH  flattened input data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel valid
- in_ready  out  CHANNELS  per-channel ready; at most one bit high
- out_data  out  WIDTH  registered output data
- out_ch  out  SEL_W  source channel of out_data
- out_valid  out  1  output valid
- out_ready  in  1  sink ready

## Operation
- Reset, when rst_n = 0 at a rising edge:
  - out_valid = 0, out_data = 0, out_ch = 0
  - round-robin pointer ptr = 0
- Load enable: load = !out_valid || out_ready. The register accepts new data while empty or while being drained in the same cycle.
- Grant (combinational):
  - Fixed mode: grant = sel when sel < CHANNELS and in_valid[sel] = 1. Otherwise there is no grant. An out-of-range sel never grants.
  - Round-robin mode: grant = the first i with in_valid[i] = 1, scanning ptr, ptr+1, … wrapping mod CHANNELS. If no input is valid, there is no grant.
- in_ready[grant] = load && grant exists. All other in_ready bits are 0. in_ready may rise regardless of in_valid only on the granted channel, so a channel's in_ready is never 1 while its in_valid is 0.
- Transfer on channel g: in_valid[g] && in_ready[g]. At the next edge:
  - out_data <= channel g data, out_ch <= g, out_valid <= 1
  - In round-robin mode, ptr <= (g+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
- Fixed mode never changes ptr. A later switch to round-robin resumes from the retained ptr.
- Output drained with no new transfer (out_valid && out_ready, no grant): out_valid <= 0. out_data and out_ch hold their last values.
- Stall (out_valid && !out_ready): out_data, out_ch and out_valid are held stable, and every in_ready bit is 0.
- Changes to mode and sel take effect combinationally in the same cycle. They never corrupt a held output.
- Reset asserted mid-stream discards the registered word. It takes priority over any transfer in that cycle.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle sustained while out_ready = 1.
- Combinational paths:
  - in_ready depends on out_ready, out_valid, in_valid, mode, sel and ptr.
  - No path from in_data to any output without a register.
- Round-robin fairness: with all channels continuously valid and out_ready = 1, grants cycle 0,1,…,CHANNELS-1,0,… Each channel waits at most CHANNELS-1 transfers between grants.

## Test plan
- Reset and idle:
  - Hold rst_n = 0 for 2 cycles with all inputs valid: out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0.
  - Release reset with in_valid = 0: outputs stay 0.
- Fixed mode, CHANNELS = 4, WIDTH = 8, out_ready = 1:
  - mode = 0, sel = 2, in_valid = 4'b1111, ch2 data = 8'hA5: in_ready = 4'b0100.
  - Next cycle: out_data = 8'hA5, out_ch = 2, out_valid = 1.
  - With sel = 5 (CHANNELS = 4, SEL_W = 2 masks to 1), use a CHANNELS = 3 build with sel = 3: no grant, and out_valid falls to 0 after drain.
- Round-robin rotation:
  - mode = 1, in_valid = 4'b1111, out_ready = 1 for 8 cycles: out_ch sequence is 0,1,2,3,0,1,2,3.
  - Then in_valid = 4'b1010 from ptr = 0: out_ch sequence is 1,3,1,3.
- Backpressure:
  - Load 8'h3C from ch1, then hold out_ready = 0 for 5 cycles: out_data = 8'h3C and out_valid = 1 stay stable, in_ready = 0.
  - Raise out_ready: a transfer and a drain occur in the same cycle, with no bubble when an input is valid.
- Reset mid-operation: with out_valid = 1 and ptr = 3, pulse rst_n = 0 for 1 cycle.
  - out_valid = 0 and ptr = 0.
  - The next round-robin grant with all channels valid goes to ch0.
- Mode switch:
  - After round-robin grants 0,1 (ptr = 2), switch to mode = 0 with sel = 0 for 3 transfers: out_ch = 0,0,0.
  - Switch back to mode = 1: the next grant is ch2.
